// File: rtl/apa102_frame_rx.sv
// APA102 receive stage: synchronises the sck/sda pins, finds the start frame,
// deframes 32-bit LED words and hands GRB pixels downstream over valid/ready.
module apa102_frame_rx #(
  parameter int IDX_W       = 8,
  parameter int IDLE_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sck_in,
  input  logic             sda_in,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [23:0]      pix_grb,
  output logic [4:0]       pix_bright,
  output logic [IDX_W-1:0] pix_index,
  output logic             frame_done,
  output logic             frame_err,
  output logic             ovf
);

  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);

  typedef enum logic {HUNT, FRAME} state_e;

  logic [2:0]       sck_sync_q;
  logic [1:0]       sda_sync_q;
  logic             sck_rise;
  logic             sda_bit;

  state_e           state_q, state_d;
  logic [5:0]       zero_run_q, zero_run_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [30:0]      shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IW-1:0]    idle_q, idle_d;
  logic [31:0]      word_w;

  logic             pend_pix_q, pend_pix_d;
  logic             pend_done_q, pend_done_d;
  logic             pend_err_q, pend_err_d;
  logic [28:0]      pend_word_q, pend_word_d;
  logic [IDX_W-1:0] pend_idx_q, pend_idx_d;

  logic             valid_q, valid_d;
  logic [23:0]      grb_q, grb_d;
  logic [4:0]       bright_q, bright_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;

  // sck and sda share the same two-flop depth so the sampled bit lines up with its edge
  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign sda_bit  = sda_sync_q[1];

  always_comb begin
    state_d     = state_q;
    zero_run_d  = zero_run_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    idle_d      = idle_q;
    pend_pix_d  = 1'b0;
    pend_done_d = 1'b0;
    pend_err_d  = 1'b0;
    pend_word_d = pend_word_q;
    pend_idx_d  = pend_idx_q;
    word_w      = {shift_q, sda_bit};

    if (sck_rise)
      idle_d = '0;
    else if (idle_q != IDLE_MAX)
      idle_d = idle_q + 1'b1;

    if (sck_rise) begin
      case (state_q)
        HUNT: begin
          if (!sda_bit) begin
            if (zero_run_q != 6'd32) zero_run_d = zero_run_q + 1'b1;
          end else if (zero_run_q == 6'd32) begin
            state_d   = FRAME;
            shift_d   = 31'd1;
            bit_cnt_d = 5'd1;
            idx_d     = '0;
          end else begin
            zero_run_d = '0;
          end
        end
        FRAME: begin
          shift_d   = word_w[30:0];
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 5'd31) begin
            if (word_w == 32'hFFFF_FFFF) begin
              pend_done_d = 1'b1;
              state_d     = HUNT;
              zero_run_d  = '0;
            end else if (word_w == 32'h0) begin
              // a zero word is another start frame, so the next 1 bit opens a new frame
              state_d    = HUNT;
              zero_run_d = 6'd32;
              idx_d      = '0;
            end else if (word_w[31:29] == 3'b111) begin
              pend_pix_d  = 1'b1;
              pend_word_d = word_w[28:0];
              pend_idx_d  = idx_q;
              idx_d       = idx_q + 1'b1;
            end else begin
              pend_err_d = 1'b1;
              state_d    = HUNT;
              zero_run_d = '0;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end else if (idle_d == IDLE_MAX) begin
      state_d    = HUNT;
      zero_run_d = '0;
      bit_cnt_d  = '0;
    end

    valid_d  = valid_q;
    grb_d    = grb_q;
    bright_d = bright_q;
    index_d  = index_q;
    ovf_d    = ovf_q;
    done_d   = pend_done_q;
    err_d    = pend_err_q;

    // a held pixel is never overwritten; the newcomer is dropped and flagged instead
    if (pend_pix_q) begin
      if (!valid_q || pix_ready) begin
        valid_d  = 1'b1;
        grb_d    = {pend_word_q[15:8], pend_word_q[7:0], pend_word_q[23:16]};
        bright_d = pend_word_q[28:24];
        index_d  = pend_idx_q;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && pix_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q  <= '0;
      sda_sync_q  <= '0;
      state_q     <= HUNT;
      zero_run_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      idx_q       <= '0;
      idle_q      <= '0;
      pend_pix_q  <= 1'b0;
      pend_done_q <= 1'b0;
      pend_err_q  <= 1'b0;
      pend_word_q <= '0;
      pend_idx_q  <= '0;
      valid_q     <= 1'b0;
      grb_q       <= '0;
      bright_q    <= '0;
      index_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[1:0], sck_in};
      sda_sync_q  <= {sda_sync_q[0], sda_in};
      state_q     <= state_d;
      zero_run_q  <= zero_run_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      idle_q      <= idle_d;
      pend_pix_q  <= pend_pix_d;
      pend_done_q <= pend_done_d;
      pend_err_q  <= pend_err_d;
      pend_word_q <= pend_word_d;
      pend_idx_q  <= pend_idx_d;
      valid_q     <= valid_d;
      grb_q       <= grb_d;
      bright_q    <= bright_d;
      index_q     <= index_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
    end
  end

  assign pix_valid  = valid_q;
  assign pix_grb    = grb_q;
  assign pix_bright = bright_q;
  assign pix_index  = index_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_apa102_frame_rx.sv
// Testbench for apa102_frame_rx: drives APA102 bit streams and compares delivered
// pixels and pulses against a word-level model of the protocol.
module tb_apa102_frame_rx;

  typedef struct packed {
    logic [23:0] grb;
    logic [4:0]  bright;
    logic [7:0]  idx;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sck_in = 1'b0;
  logic        sda_in = 1'b0;
  logic        pix_ready = 1'b0;
  logic        pix_valid;
  logic [23:0] pix_grb;
  logic [4:0]  pix_bright;
  logic [7:0]  pix_index;
  logic        frame_done;
  logic        frame_err;
  logic        ovf;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int exp_done = 0;
  int exp_err = 0;
  pix_t obs_q[$];
  pix_t exp_q[$];
  logic [31:0] words_q[$];

  apa102_frame_rx #(.IDX_W(8), .IDLE_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .sck_in(sck_in), .sda_in(sda_in),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_grb(pix_grb),
    .pix_bright(pix_bright), .pix_index(pix_index),
    .frame_done(frame_done), .frame_err(frame_err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // records every handshake and pulse away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (pix_valid && pix_ready) obs_q.push_back('{pix_grb, pix_bright, pix_index});
      if (frame_done) done_cnt++;
      if (frame_err) err_cnt++;
      if (frame_done && frame_err) both_cnt++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    sda_in = b;
    wait_clk(3);
    sck_in = 1'b1;
    wait_clk(3);
    sck_in = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  function automatic logic [31:0] rand_pixel();
    logic [31:0] w;
    w = {3'b111, 5'($urandom), 24'($urandom)};
    if (w == 32'hFFFF_FFFF) w[0] = 1'b0;
    return w;
  endfunction

  // word-level protocol model: end word, restart word, pixel, or illegal header
  task automatic model_words();
    int idx = 0;
    logic [31:0] w;
    for (int i = 0; i < words_q.size(); i++) begin
      w = words_q[i];
      if (w == 32'hFFFF_FFFF) begin
        exp_done++;
        break;
      end else if (w == 32'h0) begin
        idx = 0;
      end else if (w[31:29] == 3'b111) begin
        exp_q.push_back('{{w[15:8], w[7:0], w[23:16]}, w[28:24], 8'(idx)});
        idx = (idx + 1) % 256;
      end else begin
        exp_err++;
        break;
      end
    end
  endtask

  task automatic clear_scoreboard();
    obs_q.delete();
    exp_q.delete();
    words_q.delete();
    done_cnt = 0;
    err_cnt = 0;
    exp_done = 0;
    exp_err = 0;
  endtask

  task automatic test_reset();
    sck_in = 1'b0;
    sda_in = 1'b0;
    pix_ready = 1'b0;
    #1 rst = 1'b1;
    wait_clk(3);
    checks++;
    if ({pix_valid, frame_done, frame_err, ovf} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b want 0000", {pix_valid, frame_done, frame_err, ovf});
    end
    checks++;
    if ({pix_grb, pix_bright, pix_index} !== 37'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got %h want 0", {pix_grb, pix_bright, pix_index});
    end
    rst = 1'b0;
    wait_clk(2);
  endtask

  task automatic test_clean_frame();
    clear_scoreboard();
    pix_ready = 1'b1;
    wait_clk(80);
    words_q = '{32'hE511_2233, 32'hFFAA_BBCC, 32'hFFFF_FFFF};
    model_words();
    send_zeros(32);
    foreach (words_q[i]) send_word(words_q[i]);
    wait_clk(6);
    checks++;
    if (obs_q.size() != 2) begin
      errors++;
      $display("[TB] FAIL clean_count: got %0d want 2", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== pix_t'({24'h223311, 5'd5, 8'd0})) begin
        errors++;
        $display("[TB] FAIL clean_pix0: got %h want 223311/5/0", obs_q[0]);
      end
      checks++;
      if (obs_q[1] !== pix_t'({24'hBBCCAA, 5'd31, 8'd1})) begin
        errors++;
        $display("[TB] FAIL clean_pix1: got %h want BBCCAA/31/1", obs_q[1]);
      end
    end
    checks++;
    if (done_cnt != exp_done) begin
      errors++;
      $display("[TB] FAIL clean_done: got %0d want %0d", done_cnt, exp_done);
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clean_ovf: got %b want 0", ovf);
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 4; f++) begin
      clear_scoreboard();
      pix_ready = 1'b1;
      wait_clk(80);
      for (int k = 0; k < int'($urandom_range(1, 5)); k++) begin
        if (k > 0 && $urandom_range(0, 4) == 0) words_q.push_back(32'h0);
        words_q.push_back(rand_pixel());
      end
      words_q.push_back(32'hFFFF_FFFF);
      model_words();
      send_zeros(int'($urandom_range(32, 40)));
      foreach (words_q[i]) send_word(words_q[i]);
      wait_clk(6);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
        errors++;
        $display("[TB] FAIL rand_count[%0d]: got %0d want %0d", f, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("[TB] FAIL rand_pix[%0d.%0d]: got %h want %h", f, i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (done_cnt != exp_done || both_cnt != 0) begin
        errors++;
        $display("[TB] FAIL rand_done[%0d]: got %0d/%0d want %0d/0", f, done_cnt, both_cnt, exp_done);
      end
    end
  endtask

  task automatic test_leading_zeros();
    clear_scoreboard();
    pix_ready = 1'b1;
    wait_clk(80);
    send_zeros(40);
    send_word(32'hE100_0001);
    wait_clk(6);
    checks++;
    if (obs_q.size() != 1) begin
      errors++;
      $display("[TB] FAIL zeros40_count: got %0d want 1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== pix_t'({24'h000100, 5'd1, 8'd0})) begin
        errors++;
        $display("[TB] FAIL zeros40_pix: got %h want 000100/1/0", obs_q[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    pix_t held;
    clear_scoreboard();
    pix_ready = 1'b0;
    wait_clk(80);
    for (int k = 0; k < 3; k++) words_q.push_back(rand_pixel());
    model_words();
    send_zeros(32);
    for (int k = 0; k < 3; k++) begin
      send_word(words_q[k]);
      wait_clk(6);
      held = '{pix_grb, pix_bright, pix_index};
      checks++;
      if (pix_valid !== 1'b1 || held !== exp_q[0]) begin
        errors++;
        $display("[TB] FAIL bp_hold[%0d]: got v=%b %h want v=1 %h", k, pix_valid, held, exp_q[0]);
      end
      checks++;
      if (ovf !== (k > 0)) begin
        errors++;
        $display("[TB] FAIL bp_ovf[%0d]: got %b want %b", k, ovf, k > 0);
      end
    end
    pix_ready = 1'b1;
    wait_clk(2);
    checks++;
    if (pix_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_drop: got valid=%b want 0", pix_valid);
    end
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      errors++;
      $display("[TB] FAIL bp_deliver: got %0d items want 1 of %h", obs_q.size(), exp_q[0]);
    end
  endtask

  task automatic test_bad_header();
    clear_scoreboard();
    pix_ready = 1'b1;
    wait_clk(80);
    words_q = '{32'h6012_3456, 32'hE201_0203};
    model_words();
    send_zeros(32);
    foreach (words_q[i]) send_word(words_q[i]);
    wait_clk(6);
    checks++;
    if (err_cnt != exp_err || obs_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL bad_hdr: got err=%0d pix=%0d want err=%0d pix=0", err_cnt, obs_q.size(), exp_err);
    end
    words_q = '{32'hE201_0203};
    model_words();
    send_zeros(32);
    send_word(words_q[0]);
    wait_clk(6);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0] || err_cnt != 1) begin
      errors++;
      $display("[TB] FAIL bad_hdr_recover: got %0d pix err=%0d want %h err=1", obs_q.size(), err_cnt, exp_q[0]);
    end
  endtask

  task automatic test_idle_timeout();
    clear_scoreboard();
    pix_ready = 1'b1;
    wait_clk(80);
    send_zeros(32);
    send_bit(1'b1);
    for (int i = 0; i < 9; i++) send_bit(1'($urandom));
    wait_clk(70);
    words_q = '{rand_pixel(), rand_pixel(), 32'hFFFF_FFFF};
    model_words();
    send_zeros(32);
    foreach (words_q[i]) send_word(words_q[i]);
    wait_clk(6);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("[TB] FAIL idle_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL idle_pix[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] w;
    clear_scoreboard();
    pix_ready = 1'b0;
    wait_clk(80);
    send_zeros(32);
    send_word(rand_pixel());
    send_word(rand_pixel());
    w = rand_pixel();
    for (int i = 31; i >= 16; i--) send_bit(w[i]);
    checks++;
    if (pix_valid !== 1'b1 || ovf !== 1'b1) begin
      errors++;
      $display("[TB] FAIL arst_pre: got v=%b ovf=%b want 1/1", pix_valid, ovf);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({pix_valid, ovf, frame_done, frame_err} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL arst_immediate: got %b want 0000", {pix_valid, ovf, frame_done, frame_err});
    end
    wait_clk(2);
    rst = 1'b0;
    pix_ready = 1'b1;
    clear_scoreboard();
    wait_clk(2);
    words_q = '{rand_pixel(), rand_pixel(), 32'hFFFF_FFFF};
    model_words();
    send_zeros(32);
    foreach (words_q[i]) send_word(words_q[i]);
    wait_clk(6);
    checks++;
    if (obs_q.size() != exp_q.size() || done_cnt != exp_done) begin
      errors++;
      $display("[TB] FAIL arst_after: got %0d pix %0d done want %0d/%0d", obs_q.size(), done_cnt, exp_q.size(), exp_done);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("[TB] FAIL arst_pix[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_random_frames();
    test_leading_zeros();
    test_bad_header();
    test_idle_timeout();
    test_backpressure();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apa102_frame_rx.md
Name: apa102_frame_rx

Overview:
- Upstream receive stage of the APA102-to-WS2812 bridge.
- Synchronises the raw APA102 clock and data pins into the system clock and finds the 32-zero start frame.
- Deframes 32-bit LED words and presents one pixel at a time, in GRB order, to the WS2812 serialiser over a valid/ready handshake.
- Also reports end-of-frame, framing errors and pixel overflow.

Parameters:
- IDX_W, 8: width of the pixel index within a frame; the index wraps at 2^IDX_W.
- IDLE_CYCLES, 1024: number of clk cycles with no sck rising edge after which the receiver aborts and returns to HUNT.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- sck_in  in  1  APA102 clock pin, asynchronous to clk
- sda_in  in  1  APA102 data pin, asynchronous to clk
- pix_valid  out  1  pixel register holds an undelivered pixel
- pix_ready  in  1  consumer accepts the pixel
- pix_grb  out  24  {G,R,B} of the pixel
- pix_bright  out  5  APA102 global brightness field
- pix_index  out  IDX_W  position of the pixel in the current frame; first pixel is 0
- frame_done  out  1  one-cycle pulse when an end word is received
- frame_err  out  1  one-cycle pulse on an illegal LED header
- ovf  out  1  sticky flag: a pixel was dropped; cleared only by rst

Behaviour:
- Reset: all outputs 0; state HUNT; zero_run, bit_cnt, index counter and idle counter all 0. Reset mid-word discards everything.
- Synchronisation: sck_in and sda_in each pass through 2 flops, then sck is registered once more for edge detection.
- A bit is taken when the synchronised sck shows a rising edge. The sda value used is the one synchronised in the same cycle.
- Bits arrive MSB first.
- Pin-edge-to-bit latency is at most 3 clk. sck must stay high and low for at least 2 clk each.
- HUNT state:
  - A 0 bit increments zero_run, saturating at 32.
  - A 1 bit with zero_run<32 clears zero_run.
  - A 1 bit with zero_run==32 moves to FRAME. The shift register is loaded with that 1 and bit_cnt=1; index counter=0.
  - Extra leading zeros beyond 32 are therefore tolerated.
- FRAME state: bits shift in; on the 32nd bit (bit_cnt wraps to 0) the word w is decoded:
  - w==32'hFFFFFFFF: end word. frame_done pulses next cycle; go to HUNT with zero_run=0. No pixel is produced, so an all-ones pixel cannot be delivered.
  - w==0: restart of frame. Go to HUNT with zero_run=32; the index restarts at 0 for the next pixel.
  - w[31:29]==3'b111: pixel. bright=w[28:24], B=w[23:16], G=w[15:8], R=w[7:0]. pix_grb={G,R,B}. Index counter increments, wrapping at 2^IDX_W.
  - Any other header: frame_err pulses; go to HUNT with zero_run=0.
- Output register:
  - A decoded pixel loads pix_grb, pix_bright and pix_index on the clock after the 32nd bit, and pix_valid=1 the same cycle.
  - A transfer happens on a clk edge with pix_valid && pix_ready; pix_valid then drops unless a new pixel loads in that same cycle.
  - New pixel and a transfer in the same cycle: load the new pixel, pix_valid stays 1, nothing is dropped.
  - New pixel while pix_valid && !pix_ready: the new pixel is discarded, the register is unchanged, ovf is set and the index still advances.
  - Outputs are stable while pix_valid && !pix_ready.
- Idle timeout:
  - The idle counter clears on every sck rising edge and otherwise increments, saturating.
  - On reaching IDLE_CYCLES, in either state, the receiver goes to HUNT with zero_run=0 and bit_cnt=0, and the partial word is discarded.
  - The output register and ovf are unaffected.
  - If a timeout and an sck edge fall in the same cycle, the edge wins and the counter clears.
- frame_done and frame_err never assert in the same cycle.

Test Plan:
- Clean frame: 32 zeros, LED words E5_112233 and FF_AABBCC, then FFFFFFFF, pix_ready held 1. Required: pixel 0 grb=0x223311, bright=5, index 0; pixel 1 grb=0xBBCCAA, bright=31, index 1; then one frame_done pulse; ovf stays 0.
- 40 leading zeros, then LED word E1_000001. Required: a single pixel with grb=0x000100, bright=1, index 0.
- pix_ready held 0, three LED words sent. Required: first pixel held unchanged; ovf=1 after the second word; on raising pix_ready, index 0 is delivered and pix_valid drops.
- Bad header: start frame, then word 0x60_123456. Required: frame_err pulses once and no pixel is produced. A following start frame plus E2_010203 yields a pixel with index 0.
- Idle timeout, IDLE_CYCLES=64: after a start frame, send 10 bits then stall sck for 70 clk, then send a full frame. Required: the partial word is discarded and the first pixel of the new frame is correct with index 0.
- Async rst asserted mid-word with pix_valid=1. Required: pix_valid, ovf and all pulses go to 0 immediately; a following frame decodes correctly.
